// File: rtl/memory_responder_if.sv
// Datapath fetch/data request bus and single-port RAM handshake used by memory_responder.
// The responder takes the slave view; the datapath/RAM environment takes the master view.
interface memory_responder_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              ihit;
    logic [WORD_W-1:0] iload;
    logic              dhit;
    logic [WORD_W-1:0] dload;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_store;
    logic              ram_ack;
    logic [WORD_W-1:0] ram_load;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ack, ram_load,
        output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ack, ram_load,
        input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, err
    );
endinterface

// File: rtl/memory_responder.sv
// Serialises instruction fetches and data loads/stores onto one single-port RAM,
// returning registered hit pulses and aborting accesses that never see ram_ack.
module memory_responder #(
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               RST,
    memory_responder_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [WORD_W-1:0] WORD_ZERO  = {WORD_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_IFETCH = 2'd0,
        K_DREAD  = 2'd1,
        K_DWRITE = 2'd2
    } kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q,  kind_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ren_q,   ren_d;
    logic              wen_q,   wen_d;
    logic              ihit_q,  ihit_d;
    logic              dhit_q,  dhit_d;
    logic              err_q,   err_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;
    logic              any_req_s;

    assign any_req_s = bus.dWEN | bus.dREN | bus.iREN;

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        err_d   = 1'b0;
        iload_d = iload_q;
        dload_d = dload_q;

        case (state_q)
            S_IDLE: begin
                // Data outranks fetch (it belongs to the older instruction); write outranks read.
                if (bus.dWEN) begin
                    kind_d = K_DWRITE;
                    addr_d = bus.daddr;
                    ren_d  = 1'b0;
                    wen_d  = 1'b1;
                end else if (bus.dREN) begin
                    kind_d = K_DREAD;
                    addr_d = bus.daddr;
                    ren_d  = 1'b1;
                    wen_d  = 1'b0;
                end else if (bus.iREN) begin
                    kind_d = K_IFETCH;
                    addr_d = bus.iaddr;
                    ren_d  = 1'b1;
                    wen_d  = 1'b0;
                end else begin
                    ren_d  = 1'b0;
                    wen_d  = 1'b0;
                end

                if (any_req_s) begin
                    state_d = S_BUSY;
                    store_d = bus.dstore;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_BUSY: begin
                if (bus.ram_ack) begin
                    state_d = S_DONE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    ihit_d  = (kind_q == K_IFETCH);
                    dhit_d  = (kind_q != K_IFETCH);
                    case (kind_q)
                        K_IFETCH: iload_d = bus.ram_load;
                        K_DREAD:  dload_d = bus.ram_load;
                        default:  ;
                    endcase
                end else if (cnt_q == CNT_LIMIT) begin
                    // Still release the requester with its hit so it cannot hang.
                    state_d = S_ABORT;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    err_d   = 1'b1;
                    ihit_d  = (kind_q == K_IFETCH);
                    dhit_d  = (kind_q != K_IFETCH);
                    case (kind_q)
                        K_IFETCH: iload_d = WORD_ZERO;
                        K_DREAD:  dload_d = WORD_ZERO;
                        default:  ;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE, S_ABORT: begin
                state_d = S_IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            kind_q  <= K_IFETCH;
            addr_q  <= ADDR_ZERO;
            store_q <= WORD_ZERO;
            cnt_q   <= CNT_ZERO;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            err_q   <= 1'b0;
            iload_q <= WORD_ZERO;
            dload_q <= WORD_ZERO;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            err_q   <= err_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    assign bus.ram_ren   = ren_q;
    assign bus.ram_wen   = wen_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_store = store_q;
    assign bus.ihit      = ihit_q;
    assign bus.dhit      = dhit_q;
    assign bus.err       = err_q;
    assign bus.iload     = iload_q;
    assign bus.dload     = dload_q;
endmodule
